ctrl_seq: RTL

//  Hardwired control sequencer for the SAP-2 mini datapath. Sits downstream of the instruction register:

---
 rtl/ctrl_seq_if.sv | 14 +
 rtl/ctrl_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_if.sv
// Sequencer-side bus for ctrl_seq: opcode byte and flags in, control word and T-state out.
// master = instruction register / flag side, slave = the sequencer.
interface ctrl_seq_if;
    logic [7:0]  ins;
    logic        am;
    logic        az;
    logic        xm;
    logic        xz;
    logic [29:0] con;
    logic [5:0]  tstate;

    modport master (output ins, am, az, xm, xz, input con, tstate);
    modport slave  (input ins, am, az, xm, xz, output con, tstate);
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: hardwired control sequencer for the SAP-2 mini datapath.
// A one-hot ring steps T1..T6 (T1-T3 fetch, T4-T6 execute); con is decoded
// combinationally from the T-state, opcode byte and flags.
// Optional feature macro: CTRL_SKIP_EN -- return to T1 right after the last
// non-empty execute state instead of always running all six states.
module ctrl_seq #(
    parameter int unsigned NT = 6,
    parameter int unsigned CW = 30
) (
    input logic     clk,
    input logic     clr,
    ctrl_seq_if.slave bus
);

    // control word bit positions
    localparam int unsigned HLT = 29, LO = 28, EX = 27, DEX = 26, INX = 25, LX = 24,
                            LB = 23, EU = 22, CI = 21, M = 20, S0 = 19, S1 = 18,
                            S2 = 17, S3 = 16, EA = 15, LA = 14, EN = 13, EI = 12,
                            LI = 11, ED = 10, LD = 9, WE = 8, CE = 7, LM = 6,
                            ES = 5, CS = 4, LS = 3, EP = 2, CP = 1, LP = 0;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    tstate_e        t;
    tstate_e        next_t;
    logic           halted;
    logic [CW-1:0]  c;
    logic [5:0]     alu_f;
    logic [3:0]     op;
    logic [3:0]     sub;
    logic           cond;

    assign op  = bus.ins[7:4];
    assign sub = bus.ins[3:0];

    // flag tested by the conditional jumps
    always_comb begin
        cond = 1'b0;
        case (op)
            4'h6:    cond = bus.am;
            4'h7:    cond = bus.az;
            4'h8:    cond = bus.xm;
            4'h9:    cond = bus.xz;
            default: cond = 1'b0;
        endcase
    end

`ifdef CTRL_SKIP_EN
    logic [1:0] len;
    logic       last;

    // number of non-empty execute states for the current opcode
    always_comb begin
        len = 2'd0;
        case (op)
            4'h1, 4'hA:             len = 2'd2;
            4'h2, 4'h3, 4'h4:       len = 2'd3;
            4'h5, 4'hB, 4'hF:       len = 2'd1;
            4'h6, 4'h7, 4'h8, 4'h9: len = cond ? 2'd1 : 2'd0;
            4'hC:                   len = sub[3] ? 2'd0 : 2'd1;
            4'hD:                   len = (sub < 4'd4) ? 2'd1 : 2'd0;
            4'hE:                   len = (sub < 4'd3) ? 2'd1 : 2'd0;
            default:                len = 2'd0;
        endcase
        last = ((t == T3) && (len == 2'd0)) ||
               ((t == T4) && (len == 2'd1)) ||
               ((t == T5) && (len == 2'd2));
    end
`endif

    // ring successor, with early return to T1 when skipping is enabled
    always_comb begin
        next_t = T1;
        case (t)
            T1:      next_t = T2;
            T2:      next_t = T3;
            T3:      next_t = T4;
            T4:      next_t = T5;
            T5:      next_t = T6;
            default: next_t = T1;
        endcase
`ifdef CTRL_SKIP_EN
        if (last) next_t = T1;
`endif
    end

    // T-state ring and halt latch; halt freezes the ring until clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            t      <= T1;
            halted <= 1'b0;
        end else if (!halted) begin
            if ((t == T4) && (op == 4'hF)) halted <= 1'b1;
            t <= next_t;
        end
    end

    // control word decode
    always_comb begin
        c     = '0;
        alu_f = '0;
        if (halted) begin
            c[HLT] = 1'b1;
        end else begin
            case (t)
                T1: begin c[EP] = 1'b1; c[LM] = 1'b1; end
                T2: c[CP] = 1'b1;
                T3: begin c[CE] = 1'b1; c[LI] = 1'b1; end
                T4: begin
                    case (op)
                        4'h1, 4'h2, 4'h3, 4'h4: begin c[EI] = 1'b1; c[LM] = 1'b1; end
                        4'h5: begin c[EI] = 1'b1; c[LP] = 1'b1; end
                        4'h6, 4'h7, 4'h8, 4'h9: begin c[EI] = cond; c[LP] = cond; end
                        4'hA: begin c[EP] = 1'b1; c[LS] = 1'b1; end
                        4'hB: begin c[ES] = 1'b1; c[LP] = 1'b1; end
                        4'hC: begin
                            if (!sub[3]) begin
                                c[EU] = 1'b1;
                                c[LA] = 1'b1;
                                case (sub[2:0])
                                    3'd0:    alu_f = 6'b000010;
                                    3'd1:    alu_f = 6'b000110;
                                    3'd2:    alu_f = 6'b001110;
                                    3'd3:    alu_f = 6'b010010;
                                    3'd4:    alu_f = 6'b010110;
                                    3'd5:    alu_f = 6'b011010;
                                    3'd6:    alu_f = 6'b101110;
                                    default: alu_f = 6'b111010;
                                endcase
                            end
                        end
                        4'hD: begin
                            case (sub)
                                4'h0:    begin c[EA] = 1'b1; c[LX] = 1'b1; end
                                4'h1:    begin c[EX] = 1'b1; c[LA] = 1'b1; end
                                4'h2:    c[INX] = 1'b1;
                                4'h3:    c[DEX] = 1'b1;
                                default: ;
                            endcase
                        end
                        4'hE: begin
                            case (sub)
                                4'h0:    begin c[EN] = 1'b1; c[LA] = 1'b1; end
                                4'h1:    begin c[EA] = 1'b1; c[LO] = 1'b1; end
                                4'h2:    begin c[EA] = 1'b1; c[LB] = 1'b1; end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (op)
                        4'h1:       begin c[CE] = 1'b1; c[LA] = 1'b1; end
                        4'h2:       begin c[EA] = 1'b1; c[LD] = 1'b1; end
                        4'h3, 4'h4: begin c[CE] = 1'b1; c[LB] = 1'b1; end
                        4'hA:       begin c[EI] = 1'b1; c[LP] = 1'b1; end
                        default:    ;
                    endcase
                end
                T6: begin
                    case (op)
                        4'h2: c[WE] = 1'b1;
                        4'h3: begin c[EU] = 1'b1; c[LA] = 1'b1; alu_f = 6'b100101; end
                        4'h4: begin c[EU] = 1'b1; c[LA] = 1'b1; alu_f = 6'b011000; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        // alu_f is {s3,s2,s1,s0,m,ci}; the control word holds these bits in reverse order
        {c[S3], c[S2], c[S1], c[S0], c[M], c[CI]} = alu_f;
    end

    assign bus.con    = c;
    assign bus.tstate = NT'(t);

endmodule
